decode_sequencer: RTL and testbench

Top-level scheduler for the image decompressor. It runs the three decode stages in a fixed order: lossless decode (M3), then IDCT (M2), then upsampling/colour-space conversion (M1). It hands the single SRAM write/address port to whichever stage is active, and it reports progress, total cycle count and per-stage timeout errors. It sits between the UART loader and the VGA display controller in the top FSM.

---
 rtl/decode_sequencer.sv | 141 ++++++++++++++
 tb/tb_decode_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_sequencer.sv
// rtl/decode_sequencer.sv - runs the M3, M2 and M1 decode stages in order and owns the SRAM port mux
module decode_sequencer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        go,
  input  logic        m3_done,
  input  logic        m2_done,
  input  logic        m1_done,
  input  logic [17:0] m3_address,
  input  logic [17:0] m2_address,
  input  logic [17:0] m1_address,
  input  logic [15:0] m3_write_data,
  input  logic [15:0] m2_write_data,
  input  logic [15:0] m1_write_data,
  input  logic        m3_we_n,
  input  logic        m2_we_n,
  input  logic        m1_we_n,
  output logic        m3_start,
  output logic        m2_start,
  output logic        m1_start,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        busy,
  output logic        decode_done,
  output logic        error,
  output logic [1:0]  stage,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN_M3,
    S_RUN_M2,
    S_RUN_M1,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state;
  logic [23:0] stage_timer;
  logic        first_cycle;
  logic        timed_out;

  // The start pulse marks the first cycle of a stage, where a done level may be stale.
  assign first_cycle = m3_start | m2_start | m1_start;
  assign timed_out   = (stage_timer == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      state       <= S_IDLE;
      m3_start    <= 1'b0;
      m2_start    <= 1'b0;
      m1_start    <= 1'b0;
      stage_timer <= '0;
      cycle_count <= '0;
    end else begin
      m3_start <= 1'b0;
      m2_start <= 1'b0;
      m1_start <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (go) begin
            state       <= S_RUN_M3;
            m3_start    <= 1'b1;
            stage_timer <= '0;
            cycle_count <= '0;
          end
        end
        S_RUN_M3: begin
          cycle_count <= cycle_count + 32'd1;
          stage_timer <= stage_timer + 24'd1;
          if (m3_done && !first_cycle) begin
            state       <= S_RUN_M2;
            m2_start    <= 1'b1;
            stage_timer <= '0;
          end else if (timed_out) begin
            state <= S_ERROR;
          end
        end
        S_RUN_M2: begin
          cycle_count <= cycle_count + 32'd1;
          stage_timer <= stage_timer + 24'd1;
          if (m2_done && !first_cycle) begin
            state       <= S_RUN_M1;
            m1_start    <= 1'b1;
            stage_timer <= '0;
          end else if (timed_out) begin
            state <= S_ERROR;
          end
        end
        S_RUN_M1: begin
          cycle_count <= cycle_count + 32'd1;
          stage_timer <= stage_timer + 24'd1;
          if (m1_done && !first_cycle) begin
            state <= S_DONE;
          end else if (timed_out) begin
            state <= S_ERROR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state == S_RUN_M3) || (state == S_RUN_M2) || (state == S_RUN_M1);
  assign decode_done = (state == S_DONE);
  assign error       = (state == S_ERROR);

  // Non-owning states park the port with writes disabled so nothing stray reaches SRAM.
  always_comb begin
    stage           = 2'd0;
    SRAM_address    = '0;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    case (state)
      S_RUN_M3: begin
        stage           = 2'd3;
        SRAM_address    = m3_address;
        SRAM_write_data = m3_write_data;
        SRAM_we_n       = m3_we_n;
      end
      S_RUN_M2: begin
        stage           = 2'd2;
        SRAM_address    = m2_address;
        SRAM_write_data = m2_write_data;
        SRAM_we_n       = m2_we_n;
      end
      S_RUN_M1: begin
        stage           = 2'd1;
        SRAM_address    = m1_address;
        SRAM_write_data = m1_write_data;
        SRAM_we_n       = m1_we_n;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_decode_sequencer.sv
// tb/tb_decode_sequencer.sv - randomized scoreboard bench for decode_sequencer
module tb_decode_sequencer;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic go = 1'b0;
  logic m3_done = 1'b1;
  logic m2_done = 1'b0;
  logic m1_done = 1'b0;
  logic [17:0] m3_address = '0, m2_address = '0, m1_address = '0;
  logic [15:0] m3_write_data = '0, m2_write_data = '0, m1_write_data = '0;
  logic m3_we_n = 1'b1, m1_we_n = 1'b1, m2_we_rnd = 1'b1, pin_we = 1'b0;
  logic m2_we_n;
  logic m3_start, m2_start, m1_start;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic SRAM_we_n, busy, decode_done, error;
  logic [1:0] stage;
  logic [31:0] cycle_count;

  assign m2_we_n = pin_we ? 1'b0 : m2_we_rnd;

  decode_sequencer #(.TIMEOUT_CYCLES(24'd100)) dut (
    .CLOCK_50_I(clk), .Resetn(resetn), .go(go),
    .m3_done(m3_done), .m2_done(m2_done), .m1_done(m1_done),
    .m3_address(m3_address), .m2_address(m2_address), .m1_address(m1_address),
    .m3_write_data(m3_write_data), .m2_write_data(m2_write_data), .m1_write_data(m1_write_data),
    .m3_we_n(m3_we_n), .m2_we_n(m2_we_n), .m1_we_n(m1_we_n),
    .m3_start(m3_start), .m2_start(m2_start), .m1_start(m1_start),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
    .busy(busy), .decode_done(decode_done), .error(error), .stage(stage),
    .cycle_count(cycle_count)
  );

  typedef struct { int kind; int val; } ev_t;
  typedef struct { int stg; bit first; int term; int cnt; int off; } mdl_t;

  int vectors = 0, miscompares = 0, cyc = 0, t0 = 0;
  bit run_valid = 1'b0;
  int ml[3] = '{2, 2, 2};
  ev_t exp_q[$];

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Run timeline from stage lengths: stage n lasts min(Ln, TO) cycles, Ln > TO means timeout.
  function automatic mdl_t model_now(input int c);
    mdl_t m;
    int off, acc, d;
    m.stg = 0; m.first = 1'b0; m.term = 0; m.cnt = 0; m.off = 0;
    if (!run_valid) return m;
    off = c - t0;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      d = (ml[i] < TO) ? ml[i] : TO;
      if (off < d) begin
        m.stg = 3 - i; m.first = (off == 0); m.off = off; m.cnt = acc + off;
        return m;
      end
      off -= d;
      acc += d;
      if (ml[i] > TO) begin m.term = 2; m.cnt = acc; return m; end
    end
    m.term = 1; m.cnt = acc;
    return m;
  endfunction

  function automatic int rl();
    return int'($urandom_range(115, 2));
  endfunction

  // Stage agents: random port traffic, done raised in the last cycle of each stage and then held.
  initial forever begin
    mdl_t m;
    @(posedge clk); #1;
    m = model_now(cyc);
    m3_address = 18'($urandom); m2_address = 18'($urandom); m1_address = 18'($urandom);
    m3_write_data = 16'($urandom); m2_write_data = 16'($urandom); m1_write_data = 16'($urandom);
    m3_we_n = 1'($urandom); m2_we_rnd = 1'($urandom); m1_we_n = 1'($urandom);
    if (m.stg != 0 && m.off >= 1) begin
      case (m.stg)
        3: m3_done = (m.off >= ml[0] - 1);
        2: m2_done = (m.off >= ml[1] - 1);
        1: m1_done = (m.off >= ml[2] - 1);
        default: ;
      endcase
    end
  end

  initial begin
    mdl_t m;
    ev_t e;
    bit prev_term;
    logic [2:0] starts;
    int ak;
    prev_term = 1'b0;
    forever begin
      @(negedge clk);
      m = model_now(cyc);
      check("stage", 32'(stage), 32'(m.stg));
      check("busy", 32'(busy), 32'(m.stg != 0));
      check("decode_done", 32'(decode_done), 32'(m.term == 1));
      check("error", 32'(error), 32'(m.term == 2));
      check("cycle_count", cycle_count, 32'(m.cnt));
      check("m3_start", 32'(m3_start), 32'(m.stg == 3 && m.first));
      check("m2_start", 32'(m2_start), 32'(m.stg == 2 && m.first));
      check("m1_start", 32'(m1_start), 32'(m.stg == 1 && m.first));
      case (m.stg)
        3: begin
          check("sram_addr", 32'(SRAM_address), 32'(m3_address));
          check("sram_data", 32'(SRAM_write_data), 32'(m3_write_data));
          check("sram_we_n", 32'(SRAM_we_n), 32'(m3_we_n));
        end
        2: begin
          check("sram_addr", 32'(SRAM_address), 32'(m2_address));
          check("sram_data", 32'(SRAM_write_data), 32'(m2_write_data));
          check("sram_we_n", 32'(SRAM_we_n), 32'(m2_we_n));
        end
        1: begin
          check("sram_addr", 32'(SRAM_address), 32'(m1_address));
          check("sram_data", 32'(SRAM_write_data), 32'(m1_write_data));
          check("sram_we_n", 32'(SRAM_we_n), 32'(m1_we_n));
        end
        default: begin
          check("sram_addr", 32'(SRAM_address), 32'd0);
          check("sram_data", 32'(SRAM_write_data), 32'd0);
          check("sram_we_n", 32'(SRAM_we_n), 32'd1);
        end
      endcase
      starts = {m3_start, m2_start, m1_start};
      if (starts != 3'b000) begin
        ak = (starts == 3'b100) ? 3 : (starts == 3'b010) ? 2 : (starts == 3'b001) ? 1 : 7;
        if (exp_q.size() == 0) check("start_event", 32'(ak), 32'd0);
        else begin e = exp_q.pop_front(); check("start_event", 32'(ak), 32'(e.kind)); end
      end
      if ((decode_done | error) && !prev_term) begin
        ak = decode_done ? 4 : 5;
        if (exp_q.size() == 0) check("term_event", 32'(ak), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("term_event", 32'(ak), 32'(e.kind));
          check("term_count", cycle_count, 32'(e.val));
        end
      end
      prev_term = decode_done | error;
    end
  end

  task automatic issue_go(input int a, input int b, input int c);
    mdl_t m;
    ev_t e;
    int acc;
    bit err;
    @(negedge clk); #1;
    m = model_now(cyc);
    if (m.stg == 0) begin
      ml = '{a, b, c};
      t0 = cyc + 1;
      run_valid = 1'b1;
      acc = 0;
      err = 1'b0;
      for (int i = 0; i < 3; i++) begin
        e.kind = 3 - i; e.val = 0; exp_q.push_back(e);
        acc += (ml[i] < TO) ? ml[i] : TO;
        if (ml[i] > TO) begin err = 1'b1; break; end
      end
      e.kind = err ? 5 : 4; e.val = acc; exp_q.push_back(e);
    end
    go = 1'b1;
    @(negedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_stage(input string nm, input int want, input int min_off);
    mdl_t m;
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      m = model_now(cyc);
      if ((want < 0 && m.term != 0) || (want >= 0 && m.stg == want && m.off >= min_off)) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      vectors++; miscompares++;
      $display("FAIL %s: wait expired, got no event expected reached", nm);
    end
  endtask

  task automatic check_reset_values(input string nm);
    check({nm, "_we_n"}, 32'(SRAM_we_n), 32'd1);
    check({nm, "_addr"}, 32'(SRAM_address), 32'd0);
    check({nm, "_data"}, 32'(SRAM_write_data), 32'd0);
    check({nm, "_stage"}, 32'(stage), 32'd0);
    check({nm, "_busy"}, 32'(busy), 32'd0);
    check({nm, "_done"}, 32'(decode_done), 32'd0);
    check({nm, "_error"}, 32'(error), 32'd0);
    check({nm, "_count"}, cycle_count, 32'd0);
    check({nm, "_starts"}, 32'({m3_start, m2_start, m1_start}), 32'd0);
  endtask

  initial begin
    #1 resetn = 1'b0;
    #2 check_reset_values("reset");
    @(negedge clk); @(negedge clk); #1 resetn = 1'b1;
    repeat (3) @(negedge clk);

    // m3_done is still high from time zero: the first run exercises the stale-done guard.
    issue_go(10, 20, 30); wait_stage("normal_run", -1, 0);
    issue_go(10, 1000, 10); wait_stage("timeout_run", -1, 0);
    issue_go(10, 20, 30); wait_stage("restart_run", -1, 0);
    issue_go(5, 5, 100); wait_stage("reach_m1", 1, 3);
    issue_go(7, 7, 7); wait_stage("done_at_limit", -1, 0);

    issue_go(10, 50, 10); wait_stage("reach_m2", 2, 3);
    pin_we = 1'b1; #1;
    check("pre_reset_we_n", 32'(SRAM_we_n), 32'd0);
    resetn = 1'b0; run_valid = 1'b0; exp_q.delete(); #1;
    check_reset_values("mid_reset");
    pin_we = 1'b0;
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;
    issue_go(4, 4, 4); wait_stage("after_reset_run", -1, 0);

    for (int r = 0; r < 30; r++) begin
      issue_go(rl(), rl(), rl());
      if ($urandom_range(2, 0) == 0) begin
        repeat ($urandom_range(60, 0)) @(negedge clk);
        issue_go(rl(), rl(), rl());
      end
      wait_stage("random_run", -1, 0);
      repeat ($urandom_range(5, 0)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
